// File: rtl/rv32i_types.sv
// Shared RV32I fetch types: queue entry, fetch FSM states and small PC/counter helpers.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word inst;
    } if_entry_t;

    typedef enum logic [1:0] {
        FETCH,
        WAIT_SPACE,
        DISCARD
    } if_fetch_state_t;

    localparam rv32i_word IF_PC_STEP = 32'd4;

    function automatic rv32i_word if_next_pc(input rv32i_word pc);
        return pc + IF_PC_STEP;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/if_queue.sv
// Prefetch FIFO of {pc, inst} entries with wrapping pointers, flush and occupancy count.
module if_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  if_entry_t                push_data,
    output if_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/stage_1_if_prefetch.sv
// Fetch stage with a DEPTH-entry prefetch queue, sequential PC+4 prefetch and redirect flush.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module stage_1_if_prefetch
    import rv32i_types::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000060
) (
    input  logic            clk,
    input  logic            rst,
    output logic            inst_read,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_resp,
    input  logic [XLEN-1:0] inst_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_full_cycles
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    if_fetch_state_t state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] discard_pc_q, discard_pc_d;

    logic            push, pop;
    logic [CW-1:0]   count, count_next;
    if_entry_t       head;

    if_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ('{pc: fetch_pc_q, inst: inst_rdata}),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc   : '0;
    assign out_inst  = out_valid ? head.inst : '0;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        discard_pc_d = discard_pc_q;
        inst_read    = (state_q != WAIT_SPACE);
        inst_addr    = (state_q == DISCARD) ? discard_pc_q : fetch_pc_q;
        pop          = out_valid && out_ready && !redirect;
        push         = (state_q == FETCH) && inst_resp && !redirect;
        count_next   = count + CW'(push) - CW'(pop);

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // An unanswered request must still be drained; the memory holds that address.
            if (state_q == FETCH && !inst_resp) begin
                state_d      = DISCARD;
                discard_pc_d = fetch_pc_q;
            end else if (state_q == WAIT_SPACE) begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (inst_resp) fetch_pc_d = if_next_pc(fetch_pc_q);
                    if (count_next == CW'(DEPTH)) state_d = WAIT_SPACE;
                end
                WAIT_SPACE: begin
                    if (count_next < CW'(DEPTH)) state_d = FETCH;
                end
                DISCARD: begin
                    if (inst_resp) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            discard_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            discard_pc_q <= discard_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        dropped;
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic [31:0] perf_full_q, perf_full_d;

    always_comb begin
        dropped        = inst_read && inst_resp && (redirect || state_q == DISCARD);
        perf_fetched_d = sat_inc32(perf_fetched_q, push);
        perf_dropped_d = sat_inc32(perf_dropped_q, dropped);
        perf_full_d    = sat_inc32(perf_full_q, count == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_full_q    <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
            perf_full_q    <= perf_full_d;
        end
    end

    assign perf_fetched     = perf_fetched_q;
    assign perf_dropped     = perf_dropped_q;
    assign perf_full_cycles = perf_full_q;
`endif

`ifndef SYNTHESIS
    resp_only_when_reading: assert property (@(posedge clk) disable iff (rst) inst_resp |-> inst_read);
`endif

endmodule

// File: tb/tb_stage_1_if_prefetch.sv
// Randomized and directed bench for stage_1_if_prefetch against a queue-based reference model.
module tb_stage_1_if_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h00000060;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_dropped, perf_full_cycles;
`endif

    stage_1_if_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_read   (inst_read),
        .inst_addr   (inst_addr),
        .inst_resp   (inst_resp),
        .inst_rdata  (inst_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_dropped     (perf_dropped),
        .perf_full_cycles (perf_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of {pc, inst}, next sequential pc, and a pending abandoned request.
    logic [63:0] mq[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_disc = 1'b0;
    logic [31:0] m_disc_addr = '0;
    bit          m_known = 1'b0;
    bit          m_just_reset = 1'b0;
    int unsigned m_fetched = 0, m_dropped = 0, m_full = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    endtask

    task automatic model_clock(input bit r, input bit resp, input bit ready,
                               input bit redir, input logic [31:0] rpc);
        bit rd, acc;
        if (r) begin
            mq.delete();
            m_pc = RESET_PC;
            m_disc = 1'b0;
            m_disc_addr = '0;
            m_fetched = 0; m_dropped = 0; m_full = 0;
            m_known = 1'b1;
            m_just_reset = 1'b1;
            return;
        end
        m_just_reset = 1'b0;
        rd  = m_disc || (mq.size() < DEPTH);
        acc = rd && resp;
        if (mq.size() == DEPTH) m_full++;
        if (redir) begin
            if (acc) m_dropped++;
            if (!m_disc && rd && !resp) begin
                m_disc = 1'b1;
                m_disc_addr = m_pc;
            end
            mq.delete();
            m_pc = rpc;
        end else begin
            if (mq.size() != 0 && ready) begin
                $display("pop pc=%h inst=%h", mq[0][63:32], mq[0][31:0]);
                void'(mq.pop_front());
            end
            if (m_disc) begin
                if (acc) begin
                    m_disc = 1'b0;
                    m_dropped++;
                end
            end else if (acc) begin
                mq.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fetched++;
            end
        end
    endtask

    task automatic step(input bit rst_i, input bit resp_i, input bit ready_i,
                        input bit redir_i, input logic [31:0] rpc_i);
        bit exp_read, resp_d;
        @(negedge clk);
        rst         = rst_i;
        resp_d      = resp_i && (inst_read === 1'b1) && m_known;
        inst_resp   = resp_d;
        inst_rdata  = mem_word(inst_addr);
        out_ready   = ready_i;
        redirect    = redir_i;
        redirect_pc = rpc_i;
        #1;
        if (m_known) begin
            exp_read = m_disc || (mq.size() < DEPTH);
            check_eq("inst_read", 32'(inst_read), 32'(exp_read));
            if (exp_read) check_eq("inst_addr", inst_addr, m_disc ? m_disc_addr : m_pc);
            check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check_eq("out_pc", out_pc, mq[0][63:32]);
                check_eq("out_inst", out_inst, mq[0][31:0]);
            end
            if (m_just_reset) begin
                check_eq("rst_out_pc", out_pc, 32'h0);
                check_eq("rst_out_inst", out_inst, 32'h0);
            end
`ifdef IF_PERF_CNT_EN
            check_eq("perf_fetched", perf_fetched, m_fetched);
            check_eq("perf_dropped", perf_dropped, m_dropped);
            check_eq("perf_full_cycles", perf_full_cycles, m_full);
`endif
        end
        @(posedge clk);
        model_clock(rst_i, resp_d, ready_i, redir_i, rpc_i);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // Streaming with a consumer that never stalls.
        $display("scenario 1: streaming");
        do_reset();
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Fill the queue, hold, then release a single entry.
        $display("scenario 2: fill and single pop");
        do_reset();
        repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect while the 0x68 request is pending.
        $display("scenario 3: redirect with pending request");
        do_reset();
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000200);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a response and a ready consumer.
        $display("scenario 4: redirect with response and ready");
        do_reset();
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h00000300);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap past the top of memory.
        $display("scenario 5: pc wrap");
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        $display("scenario 6: random traffic");
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_resp, r_ready, r_redir;
            r_rst   = ($urandom_range(0, 199) == 0);
            r_resp  = ($urandom_range(0, 99) < 60);
            r_ready = (i % 400 < 100) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
            r_redir = ($urandom_range(0, 15) == 0);
            step(r_rst, r_resp, r_ready, r_redir, $urandom() & 32'hFFFFFFFC);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
